// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// cdb_arbiter_pkg : shared CDB width constants and the broadcast record type
// Revision 1.0
// =============================================================================
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH      = 5;
  localparam int CDB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic [ROB_WIDTH-1:0]      tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_t;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// =============================================================================
// cdb_arbiter_rr_pick : rotate / lowest-set-bit select / un-rotate grant picker
// Revision 1.0
// =============================================================================
module cdb_arbiter_rr_pick #(
  parameter int N_UNIT = 4,
  parameter int PTR_W  = $clog2(N_UNIT)
) (
  input  logic [N_UNIT-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [N_UNIT-1:0] grant_o
);

  logic [N_UNIT-1:0] w_rot;
  logic [N_UNIT-1:0] w_sel;

  // Bit 0 of the rotated vector is the unit rr_ptr points at.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N_UNIT; j++) begin
      w_rot[j] = req_i[(j + int'(ptr_i)) % N_UNIT];
    end
  end

  assign w_sel = w_rot & (~w_rot + N_UNIT'(1));

  always_comb begin
    grant_o = '0;
    for (int j = 0; j < N_UNIT; j++) begin
      grant_o[(j + int'(ptr_i)) % N_UNIT] = w_sel[j];
    end
  end

endmodule : cdb_arbiter_rr_pick
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// =============================================================================
// cdb_arbiter : round-robin common-data-bus arbiter, registered broadcast, flush
// Revision 1.0
// =============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_UNIT     = 4,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [N_UNIT-1:0]                    req_valid,
  input  logic [N_UNIT-1:0][ROB_WIDTH-1:0]     req_tag,
  input  logic [N_UNIT-1:0][DATA_WIDTH-1:0]    req_data,
  output logic [N_UNIT-1:0]                    req_ready,
  output cdb_t                                 cdb
);

  localparam int PTR_W = $clog2(N_UNIT);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  cdb_t                  cdb_q, cdb_d;
  logic [N_UNIT-1:0]     w_grant;
  logic [N_UNIT-1:0]     w_ready;
  logic [PTR_W-1:0]      w_gidx;
  logic [ROB_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_xfer;

  cdb_arbiter_rr_pick #(
    .N_UNIT (N_UNIT),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant)
  );

  // Gating ready (not just the register update) keeps units from believing a
  // flushed or reset-cycle result was accepted.
  assign w_ready   = (reset || flush) ? '0 : w_grant;
  assign w_xfer    = |w_ready;
  assign req_ready = w_ready;

  always_comb begin
    w_gidx = '0;
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      if (w_ready[i]) begin
        w_gidx = PTR_W'(i);
        w_tag  = req_tag[i];
        w_data = req_data[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_xfer) begin
      rr_ptr_d = (w_gidx == PTR_W'(N_UNIT - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = w_xfer;
    if (w_xfer) begin
      cdb_d.tag  = w_tag;
      cdb_d.data = w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb = cdb_q;

endmodule : cdb_arbiter
`default_nettype wire
